ama_riscv_icache: RTL

// Direct-mapped, read-only instruction cache between core fetch and the unified memory imem port.

---
 rtl/ama_riscv_icache.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/ama_riscv_icache.sv
// Direct-mapped, read-only instruction cache between core fetch and the imem line port.
// Hits answer the next cycle; misses fetch one whole line, fill it, then answer from the fill data.
module ama_riscv_icache #(
  parameter int unsigned SETS       = 8,
  parameter int unsigned LINE_W     = 128,
  parameter int unsigned MEM_ADDR_W = 14
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_core_valid,
  output logic                  req_core_ready,
  input  logic [31:0]           req_core_addr,
  output logic                  rsp_core_valid,
  output logic [31:0]           rsp_core_data,
  input  logic                  flush,
  output logic                  req_mem_valid,
  input  logic                  req_mem_ready,
  output logic [MEM_ADDR_W-1:0] req_mem_addr,
  input  logic                  rsp_mem_valid,
  input  logic [LINE_W-1:0]     rsp_mem_data
);

  localparam int unsigned IDX_W = $clog2(SETS);
  localparam int unsigned TAG_W = 32 - IDX_W - 4;

  typedef enum logic [1:0] {
    IDLE,
    MISS_REQ,
    MISS_WAIT,
    FILL_RSP
  } state_t;

  state_t state, state_nxt;

  logic [LINE_W-1:0] data_q [SETS];
  logic [TAG_W-1:0]  tag_q  [SETS];
  logic [SETS-1:0]   valid_q;
  logic              flush_pend;
  logic [31:2]       addr_q;
  logic              rsp_valid_q;
  logic [31:0]       rsp_data_q;

  logic              accept;
  logic              hit;
  logic              flush_all;
  logic              fill;

  logic [IDX_W-1:0]  req_idx;
  logic [TAG_W-1:0]  req_tag;
  logic [1:0]        req_word;
  logic [IDX_W-1:0]  miss_idx;
  logic [TAG_W-1:0]  miss_tag;
  logic [1:0]        miss_word;
  logic [LINE_W-1:0] hit_line;
  logic [31:0]       hit_word;
  logic [31:0]       fill_word;
  logic              unused_addr_bits;

  assign req_idx   = req_core_addr[IDX_W+3:4];
  assign req_tag   = req_core_addr[31:IDX_W+4];
  assign req_word  = req_core_addr[3:2];
  assign miss_idx  = addr_q[IDX_W+3:4];
  assign miss_tag  = addr_q[31:IDX_W+4];
  assign miss_word = addr_q[3:2];

  assign hit_line  = data_q[req_idx];
  assign hit_word  = hit_line[{req_word, 5'd0} +: 32];
  assign fill_word = rsp_mem_data[{miss_word, 5'd0} +: 32];

  assign unused_addr_bits = ^req_core_addr[1:0];

  assign req_mem_addr   = addr_q[MEM_ADDR_W+3:4];
  assign rsp_core_valid = rsp_valid_q;
  assign rsp_core_data  = rsp_data_q;
  assign fill           = (state == MISS_WAIT) && rsp_mem_valid;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // FILL_RSP accepts like IDLE; a pending flush masks the just-filled line as a miss
  always_comb begin
    state_nxt      = state;
    req_core_ready = 1'b0;
    req_mem_valid  = 1'b0;
    accept         = 1'b0;
    hit            = 1'b0;
    flush_all      = 1'b0;
    case (state)
      IDLE, FILL_RSP: begin
        req_core_ready = 1'b1;
        accept         = req_core_valid;
        flush_all      = flush | flush_pend;
        hit            = accept && valid_q[req_idx] && (tag_q[req_idx] == req_tag)
                         && !flush && !flush_pend;
        if (accept && !hit) state_nxt = MISS_REQ;
        else                state_nxt = IDLE;
      end
      MISS_REQ: begin
        req_mem_valid = 1'b1;
        if (req_mem_ready) state_nxt = MISS_WAIT;
      end
      MISS_WAIT: begin
        if (rsp_mem_valid) state_nxt = FILL_RSP;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q     <= '0;
      flush_pend  <= 1'b0;
      rsp_valid_q <= 1'b0;
    end else begin
      rsp_valid_q <= (accept && hit) || fill;
      if (flush_all)
        valid_q <= '0;
      else if (fill)
        valid_q[miss_idx] <= 1'b1;
      if ((state == MISS_REQ || state == MISS_WAIT) && flush)
        flush_pend <= 1'b1;
      else if (state == FILL_RSP)
        flush_pend <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (accept)
      addr_q <= req_core_addr[31:2];
    if (accept && hit)
      rsp_data_q <= hit_word;
    if (fill) begin
      data_q[miss_idx] <= rsp_mem_data;
      tag_q[miss_idx]  <= miss_tag;
      rsp_data_q       <= fill_word;
    end
  end

endmodule
